// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: Moore sequencer for the serial-frame datapath.
// Watches serin for a start bit, enables the header shift register for
// HDR_BITS cycles, loads the 3-bit counter with the header, streams data
// until the counter's carry-out, then pulses done and returns to idle.
// Outputs are registered from the next-state decode, so they always equal
// the decode of the current state with no input-to-output path.
module serial_frame_ctrl #(
    parameter int HDR_BITS = 3,
    parameter int HCW      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serin,
    input  logic       co3,
    input  logic       abort,
    output logic       hshen,
    output logic       ldcnt3,
    output logic       cnten3,
    output logic       dshen,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [HCW-1:0] HDR_LAST = HCW'(HDR_BITS - 1);

    state_t         state_q, state_d;
    logic [HCW-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [5:0]     out_q;

    // Output decode, ordered {hshen, ldcnt3, cnten3, dshen, busy, done}.
    function automatic logic [5:0] decode_outputs(input state_t s);
        logic [5:0] o;
        o = 6'b000000;
        case (s)
            S_IDLE:  o = 6'b000000;
            S_HDR:   o = 6'b100010;
            S_LOAD:  o = 6'b010010;
            S_DATA:  o = 6'b001110;
            S_DONE:  o = 6'b000011;
            default: o = 6'b000000;
        endcase
        return o;
    endfunction

    // Next-state and header-counter logic; abort overrides every transition.
    always_comb begin
        state_d   = S_IDLE;
        hdr_cnt_d = hdr_cnt_q;
        if (abort) begin
            state_d   = S_IDLE;
            hdr_cnt_d = {HCW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!serin) begin
                        state_d   = S_HDR;
                        hdr_cnt_d = {HCW{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HDR: begin
                    if (hdr_cnt_q == HDR_LAST) begin
                        state_d   = S_LOAD;
                        hdr_cnt_d = {HCW{1'b0}};
                    end else begin
                        state_d   = S_HDR;
                        hdr_cnt_d = hdr_cnt_q + HCW'(1);
                    end
                end
                S_LOAD: state_d = S_DATA;
                S_DATA: begin
                    if (co3) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: begin
                    state_d   = S_IDLE;
                    hdr_cnt_d = {HCW{1'b0}};
                end
            endcase
        end
    end

    // State, header counter and registered outputs; async reset clears all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hdr_cnt_q <= {HCW{1'b0}};
            out_q     <= 6'b000000;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            out_q     <= decode_outputs(state_d);
        end
    end

    assign {hshen, ldcnt3, cnten3, dshen, busy, done} = out_q;
    assign state_o = state_q;

endmodule
